seal_register_mc: RTL and testbench

Multi-channel, parametrised successor to the single-channel seal register. It keeps NUM_CH independent sealing channels. Each channel has its own monotonic counter, write-once session ID and staged data word, and all channels share one external CRC16 engine through a round-robin arbiter. Commits queue one-deep per channel instead of dropping while another channel is sealing, and counters saturate rather than wrap.

---
 rtl/seal_register_mc.sv | 157 +++++++++++++++
 tb/tb_seal_register_mc.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seal_register_mc.sv
// Multi-channel seal register: per-channel write-once session ID, saturating counter and
// staged data, sealed through one shared external CRC16 engine picked by round-robin.
module seal_register_mc #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int MONO_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              crc_busy,
    input  logic [15:0]       crc_value,
    output logic [7:0]        crc_byte,
    output logic              crc_feed,
    output logic              crc_init,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [31:0]       wr_data,
    input  logic              commit,
    input  logic              lock,
    input  logic [7:0]        sid_in,
    input  logic              clr,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [MONO_W-1:0] rd_mono,
    output logic [MONO_W-1:0] rd_sealed_mono,
    output logic [15:0]       rd_sealed_crc,
    output logic [7:0]        rd_status,
    output logic              seal_done,
    output logic [CH_W-1:0]   seal_ch
);

    localparam int NB    = 5 + MONO_W / 8;
    localparam int BUF_W = 40 + MONO_W;

    typedef enum logic [2:0] {IDLE, INIT, FEED, WAIT, LATCH} state_t;

    state_t state, state_nxt;

    logic [MONO_W-1:0] mono        [NUM_CH];
    logic [MONO_W-1:0] sealed_mono [NUM_CH];
    logic [15:0]       sealed_crc  [NUM_CH];
    logic [7:0]        session_id  [NUM_CH];
    logic [31:0]       data        [NUM_CH];
    logic [NUM_CH-1:0] locked, pend, drop, sat;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_ch;
    logic              grant_vld;
    logic [BUF_W-1:0]  shift_buf;
    logic [MONO_W-1:0] snap_mono;
    logic [3:0]        byte_cnt;
    logic              busy_ch;
    int                idx;

    // First pending channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_vld && pend[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_vld) state_nxt = INIT;
            INIT:    state_nxt = FEED;
            FEED:    if (!crc_busy) state_nxt = WAIT;
            WAIT:    if (!crc_busy) state_nxt = (byte_cnt == 4'(NB)) ? LATCH : FEED;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign crc_init  = (state == INIT);
    assign crc_feed  = (state == FEED) && !crc_busy;
    assign seal_done = (state == LATCH);
    assign crc_byte  = shift_buf[BUF_W-1 -: 8];

    assign busy_ch        = (state != IDLE) && (seal_ch == rd_ch);
    assign rd_mono        = mono[rd_ch];
    assign rd_sealed_mono = sealed_mono[rd_ch];
    assign rd_sealed_crc  = sealed_crc[rd_ch];
    assign rd_status      = {3'b000, busy_ch, sat[rd_ch], drop[rd_ch], pend[rd_ch], locked[rd_ch]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            seal_ch   <= '0;
            shift_buf <= '0;
            snap_mono <= '0;
            byte_cnt  <= '0;
            locked    <= '0;
            pend      <= '0;
            drop      <= '0;
            sat       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mono[i]        <= '0;
                sealed_mono[i] <= '0;
                sealed_crc[i]  <= '0;
                session_id[i]  <= '0;
                data[i]        <= '0;
            end
        end else begin
            state <= state_nxt;

            // Snapshot at grant so later writes cannot disturb the seal in flight.
            if (state == IDLE && grant_vld) begin
                seal_ch   <= grant_ch;
                snap_mono <= mono[grant_ch];
                shift_buf <= {session_id[grant_ch], mono[grant_ch], data[grant_ch]};
                byte_cnt  <= '0;
            end

            if (crc_feed) begin
                shift_buf <= shift_buf << 8;
                byte_cnt  <= byte_cnt + 4'd1;
            end

            if (state == LATCH) begin
                sealed_mono[seal_ch] <= snap_mono;
                sealed_crc[seal_ch]  <= crc_value;
                if (&mono[seal_ch])
                    sat[seal_ch] <= 1'b1;
                else
                    mono[seal_ch] <= mono[seal_ch] + MONO_W'(1);
                rr_ptr <= (seal_ch == CH_W'(NUM_CH - 1)) ? '0 : seal_ch + CH_W'(1);
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ch == CH_W'(i) && wr_en)
                    data[i] <= wr_data;
                if (wr_ch == CH_W'(i) && lock && !locked[i]) begin
                    session_id[i] <= sid_in;
                    locked[i]     <= 1'b1;
                end
                if (state == IDLE && grant_vld && grant_ch == CH_W'(i))
                    pend[i] <= 1'b0;
                if (wr_ch == CH_W'(i) && commit && locked[i] && !pend[i])
                    pend[i] <= 1'b1;
                // Set beats clear when both hit the same channel.
                if (wr_ch == CH_W'(i) && clr)
                    drop[i] <= 1'b0;
                if (wr_ch == CH_W'(i) && commit && locked[i] && pend[i])
                    drop[i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seal_register_mc.sv
// Bench for seal_register_mc: 4-channel 32-bit DUT with a CRC16-CCITT engine model, plus an
// 8-bit-counter DUT for saturation. Seal byte streams are checked by a scoreboard monitor.
module tb_seal_register_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- 32-bit, 4-channel DUT ----------------
    logic        crc_busy0;
    logic [15:0] crc0 = 16'h0000;
    logic [7:0]  crc_byte0;
    logic        crc_feed0, crc_init0;
    logic        wr_en0 = 0, commit0 = 0, lock0 = 0, clr0 = 0;
    logic [1:0]  wr_ch0 = 0, rd_ch0 = 0;
    logic [31:0] wr_data0 = 0;
    logic [7:0]  sid_in0 = 0;
    logic [31:0] rd_mono0, rd_sealed_mono0;
    logic [15:0] rd_sealed_crc0;
    logic [7:0]  rd_status0;
    logic        seal_done0;
    logic [1:0]  seal_ch0;

    seal_register_mc #(.NUM_CH(4), .CH_W(2), .MONO_W(32)) dut0 (
        .clk(clk), .rst(rst), .crc_busy(crc_busy0), .crc_value(crc0),
        .crc_byte(crc_byte0), .crc_feed(crc_feed0), .crc_init(crc_init0),
        .wr_en(wr_en0), .wr_ch(wr_ch0), .wr_data(wr_data0), .commit(commit0),
        .lock(lock0), .sid_in(sid_in0), .clr(clr0), .rd_ch(rd_ch0),
        .rd_mono(rd_mono0), .rd_sealed_mono(rd_sealed_mono0), .rd_sealed_crc(rd_sealed_crc0),
        .rd_status(rd_status0), .seal_done(seal_done0), .seal_ch(seal_ch0)
    );

    // ---------------- 8-bit counter DUT ----------------
    logic        crc_busy8 = 1'b0;
    logic [15:0] crc_value8 = 16'h0000;
    logic [7:0]  crc_byte8;
    logic        crc_feed8, crc_init8;
    logic        wr_en8 = 0, commit8 = 0, lock8 = 0, clr8 = 0;
    logic [1:0]  wr_ch8 = 0, rd_ch8 = 0;
    logic [31:0] wr_data8 = 0;
    logic [7:0]  sid_in8 = 0;
    logic [7:0]  rd_mono8, rd_sealed_mono8;
    logic [15:0] rd_sealed_crc8;
    logic [7:0]  rd_status8;
    logic        seal_done8;
    logic [1:0]  seal_ch8;

    seal_register_mc #(.NUM_CH(4), .CH_W(2), .MONO_W(8)) dut8 (
        .clk(clk), .rst(rst), .crc_busy(crc_busy8), .crc_value(crc_value8),
        .crc_byte(crc_byte8), .crc_feed(crc_feed8), .crc_init(crc_init8),
        .wr_en(wr_en8), .wr_ch(wr_ch8), .wr_data(wr_data8), .commit(commit8),
        .lock(lock8), .sid_in(sid_in8), .clr(clr8), .rd_ch(rd_ch8),
        .rd_mono(rd_mono8), .rd_sealed_mono(rd_sealed_mono8), .rd_sealed_crc(rd_sealed_crc8),
        .rd_status(rd_status8), .seal_done(seal_done8), .seal_ch(seal_ch8)
    );

    int cnt8 = 0;
    always @(posedge clk) begin
        if (rst) cnt8 <= 0;
        else if (seal_done8) cnt8 <= cnt8 + 1;
    end

    // ---------------- CRC16-CCITT engine model ----------------
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        return x;
    endfunction

    function automatic logic [15:0] exp_crc(input logic [7:0] sid, input logic [31:0] mono,
                                            input logic [31:0] data);
        logic [71:0] v;
        logic [15:0] c;
        v = {sid, mono, data};
        c = 16'hFFFF;
        for (int k = 0; k < 9; k++) c = crc_upd(c, v[71 - 8*k -: 8]);
        return c;
    endfunction

    int cyc = 0;
    int busy_cnt = 0;
    int busy_len = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign crc_busy0 = (busy_cnt != 0) || ((cyc % 7) == 3);

    always @(posedge clk) begin
        if (crc_init0) crc0 <= 16'hFFFF;
        if (crc_feed0) begin
            crc0     <= crc_upd(crc0, crc_byte0);
            busy_cnt <= busy_len;
            busy_len <= (busy_len + 1) % 4;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          ch;
        logic [7:0]  sid;
        logic [31:0] mono;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [71:0] got_v = '0;
    int          got_n = 0;
    int          seals0 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                got_n = 0;
                got_v = '0;
            end else begin
                if (crc_init0) begin
                    got_n = 0;
                    got_v = '0;
                end
                if (crc_feed0) begin
                    checks++;
                    if (crc_busy0) begin
                        failures++;
                        $display("FAIL feed_while_busy: crc_feed=1 with crc_busy=%0b", crc_busy0);
                    end
                    got_v = {got_v[63:0], crc_byte0};
                    got_n++;
                end
                if (seal_done0) begin
                    seals0++;
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_seal: seal_done on ch%0d, none expected", seal_ch0);
                    end else begin
                        mon_e = sbq.pop_front();
                        if (seal_ch0 != 2'(mon_e.ch)) begin
                            failures++;
                            $display("FAIL seal_ch: got %0d expected %0d", seal_ch0, mon_e.ch);
                        end
                        checks++;
                        if (got_n != 9 || got_v != {mon_e.sid, mon_e.mono, mon_e.data}) begin
                            failures++;
                            $display("FAIL seal_bytes ch%0d: got n=%0d %h expected n=9 %h",
                                     mon_e.ch, got_n, got_v, {mon_e.sid, mon_e.mono, mon_e.data});
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0]  m_sid  [4];
    logic [31:0] m_mono [4];
    logic [31:0] m_data [4];
    logic [15:0] m_crc  [4];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic do_lock(input int ch, input logic [7:0] sid);
        wr_ch0 = 2'(ch); sid_in0 = sid; lock0 = 1; tick(1); lock0 = 0;
    endtask

    task automatic do_write(input int ch, input logic [31:0] d);
        wr_ch0 = 2'(ch); wr_data0 = d; wr_en0 = 1; tick(1); wr_en0 = 0;
    endtask

    task automatic do_commit(input int ch);
        wr_ch0 = 2'(ch); commit0 = 1; tick(1); commit0 = 0;
    endtask

    task automatic do_clr(input int ch);
        wr_ch0 = 2'(ch); clr0 = 1; tick(1); clr0 = 0;
    endtask

    task automatic push_exp(input int ch);
        sbq.push_back('{ch, m_sid[ch], m_mono[ch], m_data[ch]});
        m_crc[ch]  = exp_crc(m_sid[ch], m_mono[ch], m_data[ch]);
        m_mono[ch] = m_mono[ch] + 1;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 3000) begin
            tick(1);
            g++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_idle: %0d seals outstanding", sbq.size());
            sbq.delete();
        end
        tick(2);
    endtask

    task automatic chk_sealed(input int ch, input logic [7:0] status);
        rd_ch0 = 2'(ch);
        #1;
        chk($sformatf("sealed_mono ch%0d", ch), rd_sealed_mono0, m_mono[ch] - 1);
        chk($sformatf("mono ch%0d", ch), rd_mono0, m_mono[ch]);
        chk($sformatf("sealed_crc ch%0d", ch), 32'(rd_sealed_crc0), 32'(m_crc[ch]));
        chk($sformatf("status ch%0d", ch), 32'(rd_status0), 32'(status));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        int nf, g, seals_before;
        for (int c = 0; c < 4; c++) begin
            m_sid[c] = 0; m_mono[c] = 0; m_data[c] = 0; m_crc[c] = 0;
        end

        rst = 1; tick(3); rst = 0; tick(1);
        for (int c = 0; c < 4; c++) begin
            rd_ch0 = 2'(c); #1;
            chk($sformatf("rst status ch%0d", c), 32'(rd_status0), 0);
            chk($sformatf("rst mono ch%0d", c), rd_mono0, 0);
            chk($sformatf("rst sealed_crc ch%0d", c), 32'(rd_sealed_crc0), 0);
        end
        chk("rst crc_feed", 32'(crc_feed0), 0);
        chk("rst seal_done", 32'(seal_done0), 0);
        chk("rst seal_ch", 32'(seal_ch0), 0);
        chk("rst mono8", 32'(rd_mono8), 0);

        // 1: basic seal of ch0
        do_lock(0, 8'hA5); m_sid[0] = 8'hA5;
        do_write(0, 32'h12345678); m_data[0] = 32'h12345678;
        do_commit(0); push_exp(0);
        wait_idle();
        chk_sealed(0, 8'h01);
        chk("t1 crc_hand", 32'(m_crc[0]), 32'(exp_crc(8'hA5, 32'h0, 32'h12345678)));

        // 2: unlocked commit ignored, relock ignored
        do_commit(1);
        rd_ch0 = 2'd1; #1;
        chk("t2 unlocked status ch1", 32'(rd_status0), 0);
        do_lock(0, 8'h3C);
        tick(20);
        chk("t2 unlocked still idle ch1", 32'(rd_status0), 0);

        // 3: four back-to-back commits, then round-robin ordering 3,1,3
        do_lock(1, 8'h11); m_sid[1] = 8'h11;
        do_lock(2, 8'h22); m_sid[2] = 8'h22;
        do_lock(3, 8'h33); m_sid[3] = 8'h33;
        do_write(1, 32'hA1B2C3D4); m_data[1] = 32'hA1B2C3D4;
        do_write(2, 32'h00FF00FF); m_data[2] = 32'h00FF00FF;
        do_write(3, 32'hCAFEF00D); m_data[3] = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) begin
            do_commit(c); push_exp(c);
        end
        wait_idle();
        for (int c = 0; c < 4; c++) chk_sealed(c, 8'h01);

        do_commit(3); push_exp(3);
        tick(2);
        do_commit(1); push_exp(1);
        do_commit(3); push_exp(3);
        rd_ch0 = 2'd3; #1;
        chk("t3 ch3 pend+busy", 32'(rd_status0), 32'h13);
        wait_idle();
        chk_sealed(1, 8'h01);
        chk_sealed(3, 8'h01);

        // 4: queued commit drops, snapshot isolation, clr
        do_commit(0); push_exp(0);
        tick(1);
        do_write(0, 32'hDEADBEEF); m_data[0] = 32'hDEADBEEF;
        do_commit(2); push_exp(2);
        do_commit(2);
        rd_ch0 = 2'd2; #1;
        chk("t4 ch2 pend+drop", 32'(rd_status0), 32'h07);
        wait_idle();
        chk_sealed(2, 8'h05);
        do_clr(2);
        rd_ch0 = 2'd2; #1;
        chk("t4 ch2 clr", 32'(rd_status0), 32'h01);
        do_commit(0); push_exp(0);
        wait_idle();
        chk_sealed(0, 8'h01);

        // 4b: clr and drop-setting commit in the same cycle: set wins
        do_commit(1); push_exp(1);
        tick(2);
        do_commit(2); push_exp(2);
        wr_ch0 = 2'd2; commit0 = 1; clr0 = 1; tick(1); commit0 = 0; clr0 = 0;
        rd_ch0 = 2'd2; #1;
        chk("t4b set beats clr", 32'(rd_status0), 32'h07);
        wait_idle();
        do_clr(2);

        // 5: saturation on the 8-bit counter DUT
        wr_ch8 = 0; sid_in8 = 8'h5A; lock8 = 1; tick(1); lock8 = 0;
        for (int k = 1; k <= 257; k++) begin
            commit8 = 1; tick(1); commit8 = 0;
            g = 0;
            while (cnt8 < k && g < 300) begin tick(1); g++; end
            if (cnt8 < k) begin
                checks++; failures++;
                $display("FAIL timeout_sat: seal %0d never completed", k);
                break;
            end
            tick(2);
            chk($sformatf("sat sealed_mono k=%0d", k), 32'(rd_sealed_mono8), (k - 1 > 255) ? 255 : k - 1);
            if (k >= 255) begin
                chk($sformatf("sat mono k=%0d", k), 32'(rd_mono8), (k > 255) ? 255 : k);
                chk($sformatf("sat status k=%0d", k), 32'(rd_status8), (k >= 256) ? 32'h09 : 32'h01);
            end
        end

        // 6: reset during the third fed byte aborts the seal
        do_commit(1);
        nf = 0; g = 0;
        while (nf < 3 && g < 500) begin
            @(negedge clk);
            if (crc_feed0) nf++;
            g++;
        end
        if (nf < 3) begin
            checks++; failures++;
            $display("FAIL timeout_feed: saw %0d feeds, needed 3", nf);
        end
        rst = 1;
        @(posedge clk); #1;
        chk("t6 crc_feed after rst", 32'(crc_feed0), 0);
        chk("t6 seal_done after rst", 32'(seal_done0), 0);
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            rd_ch0 = 2'(c); #1;
            chk($sformatf("t6 status ch%0d", c), 32'(rd_status0), 0);
            chk($sformatf("t6 mono ch%0d", c), rd_mono0, 0);
        end
        seals_before = seals0;
        tick(40);
        chk("t6 no seal after rst", 32'(seals0), 32'(seals_before));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
